// File: rtl/fir_output_requantizer_if.sv
// Output stream of the FIR requantizer: signed sample with a valid/ready handshake.
interface fir_output_requantizer_if #(
   parameter int OUT_WIDTH = 8
);
   logic signed [OUT_WIDTH-1:0] dataOut;
   logic                        dataValid;
   logic                        dataReady;

   modport master (output dataOut, output dataValid, input dataReady);
   modport slave  (input dataOut, input dataValid, output dataReady);
endinterface

// File: rtl/fir_output_requantizer.sv
// Decimates, shifts, saturates and buffers full-precision FIR output samples.
// Optional FIR_REQUANT_ROUND_EN selects round-half-up instead of floor before the shift.
module fir_output_requantizer #(
   parameter int IN_WIDTH   = 24,
   parameter int OUT_WIDTH  = 8,
   parameter int SHIFT      = 7,
   parameter int DECIM      = 1,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic signed [IN_WIDTH-1:0]    sampleIn,
   input  logic                          sampleValid,
   input  logic                          flush,
   input  logic                          clearFlags,
   fir_output_requantizer_if.master      consumer,
   output logic [$clog2(FIFO_DEPTH):0]   fifoCount,
   output logic                          satFlag,
   output logic                          dropFlag
);
   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int CNT_W   = PTR_W + 1;
   localparam int PHASE_W = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(DECIM - 1);
   localparam logic signed [IN_WIDTH:0] SAT_MAX =
      {{(IN_WIDTH - OUT_WIDTH + 2){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
   localparam logic signed [IN_WIDTH:0] SAT_MIN =
      {{(IN_WIDTH - OUT_WIDTH + 2){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

   logic [PHASE_W-1:0]          phase;
   logic                        keep;
   logic signed [IN_WIDTH:0]    widened;
   logic signed [IN_WIDTH:0]    shifted;
   logic                        s1_valid;
   logic signed [IN_WIDTH:0]    s1_value;
   logic signed [OUT_WIDTH-1:0] sat_value;
   logic                        sat_hit;
   logic signed [OUT_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]            wr_ptr;
   logic [PTR_W-1:0]            rd_ptr;
   logic [PTR_W-1:0]            rd_next;
   logic [CNT_W-1:0]            count;
   logic signed [OUT_WIDTH-1:0] head;
   logic                        data_valid;
   logic                        fifo_full;
   logic                        pop;
   logic                        push_ok;
   logic                        sat_event;
   logic                        drop_event;

   assign keep       = sampleValid && (phase == '0);
   assign data_valid = (count != '0);
   assign fifo_full  = (count == FULL_COUNT);
   assign pop        = data_valid && consumer.dataReady;
   assign push_ok    = s1_valid && !flush && (!fifo_full || pop);
   assign sat_event  = s1_valid && !flush && sat_hit;
   assign drop_event = s1_valid && !flush && fifo_full && !pop;
   assign rd_next    = rd_ptr + PTR_W'(1);

`ifdef FIR_REQUANT_ROUND_EN
   localparam logic signed [IN_WIDTH:0] ROUND_BIAS =
      (IN_WIDTH + 1)'(1) << ((SHIFT > 0) ? (SHIFT - 1) : 0);
`endif

   always_comb begin
      widened = {sampleIn[IN_WIDTH-1], sampleIn};
`ifdef FIR_REQUANT_ROUND_EN
      if (SHIFT > 0) begin
         widened = widened + ROUND_BIAS;
      end
`endif
      shifted = widened >>> SHIFT;
   end

   always_comb begin
      sat_hit   = 1'b0;
      sat_value = s1_value[OUT_WIDTH-1:0];
      if (s1_value > SAT_MAX) begin
         sat_hit   = 1'b1;
         sat_value = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
      end else if (s1_value < SAT_MIN) begin
         sat_hit   = 1'b1;
         sat_value = {1'b1, {(OUT_WIDTH - 1){1'b0}}};
      end
   end

   always_ff @(posedge clock) begin
      if (push_ok) begin
         mem[wr_ptr] <= sat_value;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         phase    <= '0;
         s1_valid <= 1'b0;
         s1_value <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         head     <= '0;
         satFlag  <= 1'b0;
         dropFlag <= 1'b0;
      end else begin
         // A new event in the clearing cycle keeps the flag set
         satFlag  <= sat_event  | (satFlag  & ~clearFlags);
         dropFlag <= drop_event | (dropFlag & ~clearFlags);
         if (flush) begin
            phase    <= '0;
            s1_valid <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
         end else begin
            if (sampleValid) begin
               phase <= (phase == LAST_PHASE) ? '0 : phase + PHASE_W'(1);
            end
            s1_valid <= keep;
            if (keep) begin
               s1_value <= shifted;
            end
            if (push_ok) begin
               wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
               rd_ptr <= rd_next;
            end
            count <= count + CNT_W'(push_ok) - CNT_W'(pop);
            // Head register gives fall-through output that holds when the FIFO drains
            if (pop && count > CNT_W'(1)) begin
               head <= mem[rd_next];
            end else if (push_ok && (count == '0 || (pop && count == CNT_W'(1)))) begin
               head <= sat_value;
            end
         end
      end
   end

   assign consumer.dataOut   = head;
   assign consumer.dataValid = data_valid;
   assign fifoCount          = count;
endmodule

// File: tb/tb_fir_output_requantizer.sv
// Directed bench for fir_output_requantizer: default instance plus a DECIM=4 instance.
module tb_fir_output_requantizer;
   logic clock = 1'b0;
   logic reset;

   logic signed [23:0] a_sample_in, b_sample_in;
   logic               a_sample_valid, b_sample_valid;
   logic               a_flush, b_flush;
   logic               a_clear_flags, b_clear_flags;
   logic [3:0]         a_fifo_count, b_fifo_count;
   logic               a_sat_flag, b_sat_flag;
   logic               a_drop_flag, b_drop_flag;

   int vectors = 0;
   int miscompares = 0;
   int b_seen[$];
   int stale_seen;
   int expected_first;

   fir_output_requantizer_if #(.OUT_WIDTH(8)) busA ();
   fir_output_requantizer_if #(.OUT_WIDTH(8)) busB ();

   fir_output_requantizer dutA (
      .clock(clock), .reset(reset),
      .sampleIn(a_sample_in), .sampleValid(a_sample_valid),
      .flush(a_flush), .clearFlags(a_clear_flags),
      .consumer(busA),
      .fifoCount(a_fifo_count), .satFlag(a_sat_flag), .dropFlag(a_drop_flag)
   );

   fir_output_requantizer #(.DECIM(4)) dutB (
      .clock(clock), .reset(reset),
      .sampleIn(b_sample_in), .sampleValid(b_sample_valid),
      .flush(b_flush), .clearFlags(b_clear_flags),
      .consumer(busB),
      .fifoCount(b_fifo_count), .satFlag(b_sat_flag), .dropFlag(b_drop_flag)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                              input logic signed [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic signed [23:0] value);
      a_sample_in    = value;
      a_sample_valid = 1'b1;
      tick();
      a_sample_valid = 1'b0;
   endtask

   task automatic captureB(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         tick();
         if (busB.dataValid) b_seen.push_back(int'(busB.dataOut));
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset = 1'b1;
      a_sample_in = '0; a_sample_valid = 1'b0; a_flush = 1'b0; a_clear_flags = 1'b0;
      b_sample_in = '0; b_sample_valid = 1'b0; b_flush = 1'b0; b_clear_flags = 1'b0;
      busA.dataReady = 1'b0;
      busB.dataReady = 1'b1;
      tick();
      tick();
      checkOutput("reset_dataOut", busA.dataOut, 0);
      checkOutput("reset_dataValid", busA.dataValid, 0);
      checkOutput("reset_fifoCount", a_fifo_count, 0);
      checkOutput("reset_satFlag", a_sat_flag, 0);
      checkOutput("reset_dropFlag", a_drop_flag, 0);
      reset = 1'b0;

      // Single sample latency and scaling
`ifdef FIR_REQUANT_ROUND_EN
      expected_first = 8;
`else
      expected_first = 7;
`endif
      applyStimulus(24'sd1000);
      checkOutput("latency_early_valid", busA.dataValid, 0);
      tick();
      checkOutput("single_valid", busA.dataValid, 1);
      checkOutput("single_dataOut", busA.dataOut, expected_first);
      checkOutput("single_satFlag", a_sat_flag, 0);
      checkOutput("single_fifoCount", a_fifo_count, 1);
      busA.dataReady = 1'b1;
      tick();
      checkOutput("single_drained_valid", busA.dataValid, 0);
      checkOutput("single_hold_dataOut", busA.dataOut, expected_first);

      // Saturation in both directions, then flag clear
      a_sample_in = 24'sd20000; a_sample_valid = 1'b1;
      tick();
      a_sample_in = -24'sd20000;
      tick();
      checkOutput("sat_pos_dataOut", busA.dataOut, 127);
      checkOutput("sat_flag_set", a_sat_flag, 1);
      a_sample_in = -24'sd200;
      tick();
      checkOutput("sat_neg_dataOut", busA.dataOut, -128);
      a_sample_valid = 1'b0;
      tick();
      checkOutput("sat_small_neg_dataOut", busA.dataOut, -2);
      checkOutput("sat_small_neg_valid", busA.dataValid, 1);
      tick();
      checkOutput("sat_drained_valid", busA.dataValid, 0);
      a_clear_flags = 1'b1;
      tick();
      a_clear_flags = 1'b0;
      checkOutput("sat_flag_cleared", a_sat_flag, 0);

      // Overflow: nine samples into an eight-entry FIFO with no consumer
      busA.dataReady = 1'b0;
      for (int i = 1; i <= 9; i++) begin
         a_sample_in = 24'(128 * i); a_sample_valid = 1'b1;
         tick();
      end
      a_sample_valid = 1'b0;
      tick();
      checkOutput("ovf_fifoCount", a_fifo_count, 8);
      checkOutput("ovf_dropFlag", a_drop_flag, 1);
      busA.dataReady = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         checkOutput($sformatf("ovf_pop_%0d", i), busA.dataOut, i);
         tick();
      end
      checkOutput("ovf_drained_valid", busA.dataValid, 0);
      checkOutput("ovf_drained_count", a_fifo_count, 0);

      // Full FIFO with a push and pop in the same cycle
      a_clear_flags = 1'b1;
      tick();
      a_clear_flags = 1'b0;
      busA.dataReady = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         a_sample_in = 24'(128 * i); a_sample_valid = 1'b1;
         tick();
      end
      a_sample_in = 24'sd1280;
      tick();
      a_sample_valid = 1'b0;
      checkOutput("full_fifoCount", a_fifo_count, 8);
      busA.dataReady = 1'b1;
      tick();
      checkOutput("full_pushpop_count", a_fifo_count, 8);
      checkOutput("full_pushpop_drop", a_drop_flag, 0);
      for (int i = 2; i <= 8; i++) begin
         checkOutput($sformatf("full_pop_%0d", i), busA.dataOut, i);
         tick();
      end
      checkOutput("full_last_entry", busA.dataOut, 10);
      tick();
      checkOutput("full_drained_valid", busA.dataValid, 0);

      // Decimation by four on the second instance
      for (int i = 1; i <= 8; i++) begin
         b_sample_in = 24'(128 * i); b_sample_valid = 1'b1;
         tick();
         if (busB.dataValid) b_seen.push_back(int'(busB.dataOut));
      end
      b_sample_valid = 1'b0;
      captureB(4);
      checkOutput("decim_count", b_seen.size(), 2);
      checkOutput("decim_first", (b_seen.size() > 0) ? b_seen[0] : -999, 1);
      checkOutput("decim_second", (b_seen.size() > 1) ? b_seen[1] : -999, 5);
      b_seen.delete();
      b_sample_in = 24'sd2560; b_sample_valid = 1'b1;
      tick();
      b_sample_valid = 1'b0;
      captureB(4);
      checkOutput("decim_wrap_value", (b_seen.size() > 0) ? b_seen[0] : -999, 20);
      b_seen.delete();
      b_flush = 1'b1;
      tick();
      b_flush = 1'b0;
      b_sample_in = 24'sd1152; b_sample_valid = 1'b1;
      tick();
      b_sample_valid = 1'b0;
      captureB(4);
      checkOutput("flush_count", b_seen.size(), 1);
      checkOutput("flush_phase_restart", (b_seen.size() > 0) ? b_seen[0] : -999, 9);

      // Reset with five entries queued and one sample in flight
      busA.dataReady = 1'b0;
      a_sample_in = 24'sd20000; a_sample_valid = 1'b1;
      tick();
      for (int i = 2; i <= 6; i++) begin
         a_sample_in = 24'(128 * i);
         tick();
      end
      a_sample_valid = 1'b0;
      checkOutput("pre_reset_count", a_fifo_count, 5);
      checkOutput("pre_reset_satFlag", a_sat_flag, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checkOutput("midreset_count", a_fifo_count, 0);
      checkOutput("midreset_valid", busA.dataValid, 0);
      checkOutput("midreset_dataOut", busA.dataOut, 0);
      checkOutput("midreset_satFlag", a_sat_flag, 0);
      checkOutput("midreset_dropFlag", a_drop_flag, 0);
      busA.dataReady = 1'b1;
      stale_seen = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (busA.dataValid) stale_seen++;
      end
      checkOutput("no_stale_sample", stale_seen, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/fir_output_requantizer.md
Name: fir_output_requantizer

Overview:
Downstream stage of the n-tap FIR filter. It consumes the filter's full-precision signed output, which is DATA_WIDTH*3 bits wide. Each sample is decimated, scaled by an arithmetic right shift, saturated to a narrow output width and buffered in a small FIFO. The FIFO presents samples to the next consumer over a valid/ready handshake.
The filter has no backpressure, so this block absorbs bursts and reports any lost samples.

Parameters:
IN_WIDTH, 24, width of signed input sample (matches FIR output, 3*8)
OUT_WIDTH, 8, width of signed output sample; 2 <= OUT_WIDTH < IN_WIDTH
SHIFT, 7, arithmetic right-shift amount applied before saturation; 0 <= SHIFT < IN_WIDTH
DECIM, 1, decimation factor; keep 1 of every DECIM valid samples; 1..256
FIFO_DEPTH, 8, output FIFO entries; power of 2, >= 2

Ports:
clock  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous active-high reset
sampleIn  input  IN_WIDTH  signed FIR output sample
sampleValid  input  1  sampleIn is a new sample this cycle
flush  input  1  synchronous clear of FIFO, pipeline and decimation phase; flags unaffected
clearFlags  input  1  synchronous clear of satFlag and dropFlag
dataOut  output  OUT_WIDTH  signed FIFO head sample (first-word fall-through)
dataValid  output  1  FIFO not empty
dataReady  input  1  consumer accepts dataOut when dataValid && dataReady
fifoCount  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
satFlag  output  1  sticky: at least one kept sample was saturated
dropFlag  output  1  sticky: at least one kept sample was discarded because the FIFO was full

Behaviour:
- Reset (reset=1 at an edge):
  - dataOut=0, dataValid=0, fifoCount=0, satFlag=0, dropFlag=0.
  - Read and write pointers = 0, decimation phase = 0, pipeline valid bits = 0.
  - Reset has priority over every other input, including mid-burst; in-flight samples are discarded.
- Priority below reset: flush, then clearFlags, then normal operation.
  - flush empties the FIFO, zeroes the phase and invalidates stage 1; a sample presented in the flush cycle is discarded.
  - clearFlags in the same cycle as a new saturation or drop event leaves the flag set (set wins).
- Decimation phase counter (0..DECIM-1):
  - Advances on every cycle with sampleValid=1 and wraps from DECIM-1 to 0.
  - A sample is kept when the phase is 0, i.e. the 1st, (DECIM+1)th, and so on after reset or flush.
  - With DECIM=1 every sample is kept.
- Stage 1 (edge k, kept sample): register the shifted value, sampleIn >>> SHIFT, sign-extended to IN_WIDTH+1 bits.
- Stage 2 (edge k+1), saturate to OUT_WIDTH:
  - Value > 2^(OUT_WIDTH-1)-1 gives the maximum positive code and sets satFlag.
  - Value < -2^(OUT_WIDTH-1) gives the minimum negative code and sets satFlag.
  - Otherwise the value passes unchanged.
  - The result is written to the FIFO at the same edge.
- Latency: sample at edge k appears as dataOut with dataValid=1 after edge k+1 when the FIFO was empty. Throughput is 1 sample/cycle.
- FIFO write with FIFO full: the sample is dropped, dropFlag=1, FIFO contents unchanged.
  - Exception: a pop in the same cycle frees a slot, so the write succeeds and fifoCount stays FIFO_DEPTH.
- FIFO pop when dataValid && dataReady:
  - The read pointer advances, wrapping modulo FIFO_DEPTH.
  - dataOut shows the next entry after the edge.
- Simultaneous push and pop: fifoCount unchanged.
- dataReady with dataValid=0 has no effect.
- dataOut holds its last value when empty.
- Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. Full/empty are derived from fifoCount.

Optional Feature:
FIR_REQUANT_ROUND_EN
- Defined, with SHIFT>0: stage 1 adds 2^(SHIFT-1) to sampleIn, in IN_WIDTH+1 bits, before the shift. This gives round-half-up.
- Defined, with SHIFT=0: no effect.
- Undefined: pure truncation toward negative infinity (floor).
- Saturation, latency and flags are identical in both builds.

Test Plan:
- Reset then single sample: defaults, sampleIn=1000, sampleValid for 1 cycle -> dataValid rises 2 edges later.
  - Truncating build: dataOut=7.
  - FIR_REQUANT_ROUND_EN build: dataOut=8.
  - In both builds: satFlag=0, fifoCount=1.
- Saturation: samples 20000, -20000, -200 with dataReady=1.
  - Outputs 127, -128, -2 in order.
  - satFlag=1 after the first sample.
  - clearFlags pulse -> satFlag=0.
- Decimation: DECIM=4, sampleValid continuous, sampleIn=128*i for i=1..8.
  - Exactly 2 outputs: 1 and 5.
  - Then flush and feed 128*9 -> output 9 (phase restarted).
- Overflow: dataReady=0, feed 9 samples 128*i.
  - fifoCount=8, dropFlag=1.
  - Raise dataReady -> outputs 1..8 in order, 9 is never seen, dataValid falls after 8 pops.
- Full with simultaneous pop: FIFO full, dataReady=1 while sampleValid=1 -> no drop, fifoCount stays 8, new sample appears last.
- Reset mid-operation: assert reset with 5 entries queued and a sample in stage 1.
  - Next cycle: fifoCount=0, dataValid=0, dataOut=0, flags=0.
  - No stale sample emerges afterward.
